fft_butterfly_sequencer: RTL and testbench

//  Sequences one shared combinational radix-2 butterfly over an in-place N-point DIT FFT.

---
 rtl/fft_butterfly_sequencer_if.sv | 34 +++
 rtl/fft_butterfly_sequencer.sv | 72 +++++++
 tb/tb_fft_butterfly_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_butterfly_sequencer_if.sv
// fft_butterfly_sequencer_if: control, sample RAM, twiddle ROM and butterfly signals of the FFT sequencer
interface fft_butterfly_sequencer_if #(parameter int LOG2N = 4, parameter int DW = 32);
  logic start;
  logic busy;
  logic done;
  logic [LOG2N-1:0] stage;
  logic mem_rd_en;
  logic [LOG2N-1:0] mem_rd_addr_a;
  logic [LOG2N-1:0] mem_rd_addr_b;
  logic [DW-1:0] mem_rd_data_a;
  logic [DW-1:0] mem_rd_data_b;
  logic [LOG2N-2:0] tw_addr;
  logic [DW-1:0] tw_data;
  logic [DW-1:0] bf_a;
  logic [DW-1:0] bf_b;
  logic [DW-1:0] bf_w;
  logic [DW-1:0] bf_out1;
  logic [DW-1:0] bf_out2;
  logic mem_wr_en;
  logic [LOG2N-1:0] mem_wr_addr_a;
  logic [LOG2N-1:0] mem_wr_addr_b;
  logic [DW-1:0] mem_wr_data_a;
  logic [DW-1:0] mem_wr_data_b;
  modport master (
    input start, mem_rd_data_a, mem_rd_data_b, tw_data, bf_out1, bf_out2,
    output busy, done, stage, mem_rd_en, mem_rd_addr_a, mem_rd_addr_b, tw_addr,
    output bf_a, bf_b, bf_w, mem_wr_en, mem_wr_addr_a, mem_wr_addr_b, mem_wr_data_a, mem_wr_data_b
  );
  modport slave (
    output start, mem_rd_data_a, mem_rd_data_b, tw_data, bf_out1, bf_out2,
    input busy, done, stage, mem_rd_en, mem_rd_addr_a, mem_rd_addr_b, tw_addr,
    input bf_a, bf_b, bf_w, mem_wr_en, mem_wr_addr_a, mem_wr_addr_b, mem_wr_data_a, mem_wr_data_b
  );
endinterface

// File: rtl/fft_butterfly_sequencer.sv
// fft_butterfly_sequencer: walks LOG2N stages x N/2 butterflies of an in-place radix-2 DIT FFT
module fft_butterfly_sequencer #(parameter int LOG2N = 4, parameter int DW = 32) (
  input logic clk,
  input logic reset_n,
  fft_butterfly_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_d;
  logic [LOG2N-1:0] s, s_d, sh, addr_a, addr_b;
  logic [LOG2N-2:0] k, k_d, mask, j;
  logic run, last_s;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      s <= '0;
      k <= '0;
      bus.mem_wr_en <= 1'b0;
      bus.mem_wr_addr_a <= '0;
      bus.mem_wr_addr_b <= '0;
    end else begin
      state <= state_d;
      s <= s_d;
      k <= k_d;
      bus.mem_wr_en <= run;
      bus.mem_wr_addr_a <= bus.mem_rd_addr_a;
      bus.mem_wr_addr_b <= bus.mem_rd_addr_b;
    end
  always_comb begin
    state_d = state;
    s_d = s;
    k_d = k;
    run = state == RUN;
    last_s = s == LOG2N'(LOG2N-1);
    case (state)
      IDLE: if (bus.start) begin
        state_d = RUN;
        s_d = '0;
        k_d = '0;
      end
      RUN: begin
        k_d = k + 1'b1;
        state_d = k == '1 ? DRAIN : RUN;
      end
      DRAIN: begin
        state_d = last_s ? DONE : RUN;
        s_d = last_s ? s : s + 1'b1;
        k_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  // j = k mod 2**s; group base = k with low s bits cleared, doubled
  always_comb begin
    mask = ~({(LOG2N-1){1'b1}} << s);
    j = k & mask;
    sh = LOG2N'(LOG2N-1) - s;
    addr_a = {k & ~mask, 1'b0} | {1'b0, j};
    addr_b = addr_a | (LOG2N'(1) << s);
    bus.mem_rd_en = run;
    bus.mem_rd_addr_a = run ? addr_a : '0;
    bus.mem_rd_addr_b = run ? addr_b : '0;
    bus.tw_addr = run ? j << sh : '0;
    bus.busy = state == RUN || state == DRAIN;
    bus.done = state == DONE;
    bus.stage = s;
    bus.bf_a = bus.mem_rd_data_a;
    bus.bf_b = bus.mem_rd_data_b;
    bus.bf_w = bus.tw_data;
    bus.mem_wr_data_a = bus.bf_out1;
    bus.mem_wr_data_b = bus.bf_out2;
  end
endmodule

// File: tb/tb_fft_butterfly_sequencer.sv
// tb_fft_butterfly_sequencer: directed checks of sequencing, timing, reset and end-to-end FFT results
module tb_fft_butterfly_sequencer;
  localparam int LOG2N = 4;
  localparam int N = 16;
  localparam int DW = 32;
  localparam int COS[8] = '{32767, 30274, 23170, 12540, 0, -12540, -23170, -30274};
  localparam int SIN[8] = '{0, 12540, 23170, 30274, 32767, 30274, 23170, 12540};
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int failures = 0;
  fft_butterfly_sequencer_if #(.LOG2N(LOG2N), .DW(DW)) bus();
  fft_butterfly_sequencer #(.LOG2N(LOG2N), .DW(DW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  logic [DW-1:0] ram [N];
  logic [DW-1:0] load_img [N];
  logic [DW-1:0] gold [N];
  logic load = 1'b0;
  int nr = 0, nw = 0, wr_bad = 0;
  logic [3:0] ra [512];
  logic [3:0] rb [512];
  logic [2:0] rt [512];
  logic [3:0] rs [512];
  logic prd = 1'b0;
  logic [3:0] pa = '0, pb = '0;

  function automatic logic [31:0] twiddle(input int i);
    return {16'(COS[i]), 16'(-SIN[i])};
  endfunction

  // Q1.15 butterfly with 1/2 scaling per stage: out1=(a+w*b)/2, out2=(a-w*b)/2
  function automatic logic [63:0] bfly(input logic [31:0] a, input logic [31:0] b, input logic [31:0] w);
    int ar, ai, br, bi, wr, wi, tr, ti;
    ar = int'($signed(a[31:16]));
    ai = int'($signed(a[15:0]));
    br = int'($signed(b[31:16]));
    bi = int'($signed(b[15:0]));
    wr = int'($signed(w[31:16]));
    wi = int'($signed(w[15:0]));
    tr = (wr * br - wi * bi) >>> 15;
    ti = (wr * bi + wi * br) >>> 15;
    return {16'((ar + tr) >>> 1), 16'((ai + ti) >>> 1), 16'((ar - tr) >>> 1), 16'((ai - ti) >>> 1)};
  endfunction

  function automatic logic [3:0] bitrev(input logic [3:0] x);
    return {x[0], x[1], x[2], x[3]};
  endfunction

  always_comb {bus.bf_out1, bus.bf_out2} = bfly(bus.bf_a, bus.bf_b, bus.bf_w);

  always @(posedge clk) begin
    if (load) ram <= load_img;
    if (bus.mem_rd_en) begin
      bus.mem_rd_data_a <= ram[bus.mem_rd_addr_a];
      bus.mem_rd_data_b <= ram[bus.mem_rd_addr_b];
      bus.tw_data <= twiddle(int'(bus.tw_addr));
    end
    if (bus.mem_wr_en) begin
      ram[bus.mem_wr_addr_a] <= bus.mem_wr_data_a;
      ram[bus.mem_wr_addr_b] <= bus.mem_wr_data_b;
    end
  end

  always @(negedge clk) begin
    if (bus.mem_rd_en && nr < 512) begin
      ra[nr] = bus.mem_rd_addr_a;
      rb[nr] = bus.mem_rd_addr_b;
      rt[nr] = bus.tw_addr;
      rs[nr] = bus.stage;
      nr++;
    end
    if (bus.mem_wr_en) begin
      nw++;
      if (!prd || bus.mem_wr_addr_a !== pa || bus.mem_wr_addr_b !== pb) wr_bad++;
    end
    prd = bus.mem_rd_en;
    pa = bus.mem_rd_addr_a;
    pb = bus.mem_rd_addr_b;
  end

  task automatic do_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(posedge clk);
      #1;
      ok = bus.done;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int b0, w0;
    b0 = nr;
    w0 = nw;
    bus.start = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.mem_rd_en, bus.mem_wr_en} !== 4'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000", {bus.busy, bus.done, bus.mem_rd_en, bus.mem_wr_en});
    end
    checks++;
    if ({bus.stage, bus.mem_rd_addr_a, bus.mem_rd_addr_b, bus.tw_addr, bus.mem_wr_addr_a, bus.mem_wr_addr_b} !== 23'b0) begin
      failures++;
      $display("FAIL reset_addr got=%h exp=0", {bus.stage, bus.mem_rd_addr_a, bus.mem_rd_addr_b, bus.tw_addr, bus.mem_wr_addr_a, bus.mem_wr_addr_b});
    end
    checks++;
    if ((nr - b0) + (nw - w0) != 0) begin
      failures++;
      $display("FAIL reset_accesses got=%0d exp=0", (nr - b0) + (nw - w0));
    end
    @(negedge clk);
    bus.start = 1'b0;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_busy got=%b exp=0", bus.busy);
    end
  endtask

  task automatic test_address_trace();
    int b0, w0, bad0;
    bit ok;
    int idx [4] = '{0, 1, 9, 29};
    logic [14:0] exp [4] = '{{4'd0, 4'd1, 3'd0, 4'd0}, {4'd2, 4'd3, 3'd0, 4'd0},
                             {4'd1, 4'd3, 3'd4, 4'd1}, {4'd5, 4'd13, 3'd5, 4'd3}};
    b0 = nr;
    w0 = nw;
    bad0 = wr_bad;
    do_start();
    wait_done(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL trace_done_timeout got=0 exp=1"); end
    checks++;
    if (nr - b0 != 32 || nw - w0 != 32) begin
      failures++;
      $display("FAIL trace_counts reads=%0d writes=%0d exp=32/32", nr - b0, nw - w0);
    end
    checks++;
    if (wr_bad != bad0) begin failures++; $display("FAIL trace_wr_addr bad=%0d exp=0", wr_bad - bad0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({ra[b0 + idx[i]], rb[b0 + idx[i]], rt[b0 + idx[i]], rs[b0 + idx[i]]} !== exp[i]) begin
        failures++;
        $display("FAIL trace_entry%0d got a=%0d b=%0d tw=%0d s=%0d exp a=%0d b=%0d tw=%0d s=%0d", idx[i],
                 ra[b0 + idx[i]], rb[b0 + idx[i]], rt[b0 + idx[i]], rs[b0 + idx[i]],
                 exp[i][14:11], exp[i][10:7], exp[i][6:4], exp[i][3:0]);
      end
    end
  endtask

  task automatic test_timing();
    int w0;
    logic [3:0] ev;
    w0 = nw;
    do_start();
    for (int e = 0; e <= 40; e++) begin
      if (e > 0) begin @(posedge clk); #1; end
      ev = {e < 36, e == 36, e < 36 && e % 9 < 8, e >= 1 && e <= 36 && (e - 1) % 9 < 8};
      checks++;
      if ({bus.busy, bus.done, bus.mem_rd_en, bus.mem_wr_en} !== ev) begin
        failures++;
        $display("FAIL timing_e%0d busy/done/rd/wr got=%b exp=%b", e, {bus.busy, bus.done, bus.mem_rd_en, bus.mem_wr_en}, ev);
      end
    end
    checks++;
    if (nw - w0 != 32) begin failures++; $display("FAIL timing_writes got=%0d exp=32", nw - w0); end
  endtask

  task automatic test_start_held();
    int b0;
    bit ok;
    b0 = nr;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    repeat (36) @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b1 || nr - b0 != 32) begin
      failures++;
      $display("FAIL held_first done=%b reads=%0d exp 1/32", bus.done, nr - b0);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.mem_rd_en} !== 3'b0) begin
      failures++;
      $display("FAIL held_idle got=%b exp=000", {bus.busy, bus.done, bus.mem_rd_en});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.mem_rd_en} !== 2'b11) begin
      failures++;
      $display("FAIL held_restart got=%b exp=11", {bus.busy, bus.mem_rd_en});
    end
    bus.start = 1'b0;
    wait_done(ok);
    checks++;
    if (!ok || nr - b0 != 64) begin
      failures++;
      $display("FAIL held_second done=%b reads=%0d exp 1/64", ok, nr - b0);
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    do_start();
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (bus.mem_wr_en !== 1'b1 || bus.stage !== 4'd2) begin
      failures++;
      $display("FAIL midreset_pre wr=%b stage=%0d exp 1/2", bus.mem_wr_en, bus.stage);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.mem_wr_en, bus.mem_rd_en, bus.busy} !== 3'b0 || bus.stage !== 4'd0) begin
      failures++;
      $display("FAIL midreset_async wr/rd/busy=%b stage=%0d exp 000/0", {bus.mem_wr_en, bus.mem_rd_en, bus.busy}, bus.stage);
    end
    w0 = nw;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (nw != w0) begin failures++; $display("FAIL midreset_writes got=%0d exp=0", nw - w0); end
    @(negedge clk);
    reset_n = 1'b1;
    test_address_trace();
  endtask

  task automatic test_end_to_end(input bit tone);
    bit ok;
    int half;
    logic [31:0] x, exp;
    for (int n = 0; n < N; n++) begin
      x = tone ? (n % 4 == 0 ? 32'h4000_0000 : n % 4 == 2 ? 32'hC000_0000 : 32'h0)
               : (n == 0 ? 32'h7FFF_0000 : 32'h0);
      load_img[bitrev(4'(n))] = x;
      gold[bitrev(4'(n))] = x;
    end
    @(negedge clk);
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    for (int s = 0; s < LOG2N; s++) begin
      half = 1 << s;
      for (int base = 0; base < N; base += 2 * half)
        for (int j = 0; j < half; j++)
          {gold[base + j], gold[base + j + half]} = bfly(gold[base + j], gold[base + j + half], twiddle(j * (N / (2 * half))));
    end
    do_start();
    wait_done(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL e2e%0d_done_timeout got=0 exp=1", tone); end
    for (int i = 0; i < N; i++) begin
      exp = tone ? gold[i] : 32'h07FF_0000;
      checks++;
      if (ram[i] !== exp) begin
        failures++;
        $display("FAIL e2e%0d_word%0d got=%h exp=%h", tone, i, ram[i], exp);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    test_reset();
    test_address_trace();
    test_timing();
    test_start_held();
    test_reset_mid();
    test_end_to_end(1'b0);
    test_end_to_end(1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
